dds_wave_gen: RTL

Parametrised direct-digital-synthesis waveform generator and successor to the fixed 32-bit square-wave DDS. It uses a double-buffered frequency and phase tuning interface with an explicit load strobe and a synchronous phase clear. Four selectable waveforms come out of a 3-stage pipeline. It sits between the control/register logic that writes tuning words and the DAC or PWM back end that consumes `wave_out`/`f_out`.

---
 rtl/dds_wave_gen.sv | 119 +++++++++++
 1 files changed

// File: rtl/dds_wave_gen.sv
// Direct-digital-synthesis waveform generator.
// Double-buffered tuning words (k/p/mode) captured on load, a phase
// accumulator with synchronous clear, and a three-stage pipeline that
// produces square, sawtooth, triangle or inverted-sawtooth samples.
module dds_wave_gen #(
    parameter int ACC_W   = 32,
    parameter int PHASE_W = 11,
    parameter int OUT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               load,
    input  logic [ACC_W-1:0]   k_in,
    input  logic [PHASE_W-1:0] p_in,
    input  logic [1:0]         mode,
    input  logic               sync_clr,
    output logic               f_out,
    output logic [OUT_W-1:0]   wave_out,
    output logic               wave_valid,
    output logic               wrap
);

    // Maps a truncated phase to an amplitude sample for the selected waveform.
    function automatic logic [OUT_W-1:0] shape_wave(
        input logic [PHASE_W-1:0] ph,
        input logic [1:0]         sel
    );
        logic [OUT_W-1:0] saw;
        logic [OUT_W-1:0] tri_v;
        saw   = ph[PHASE_W-1 -: OUT_W];
        // Triangle uses the bits below the MSB so one half-period spans full scale.
        tri_v = ph[PHASE_W-2 -: OUT_W];
        case (sel)
            2'd0:    shape_wave = {OUT_W{ph[PHASE_W-1]}};
            2'd1:    shape_wave = saw;
            2'd2:    shape_wave = ph[PHASE_W-1] ? ~tri_v : tri_v;
            default: shape_wave = ~saw;
        endcase
    endfunction

    logic [ACC_W-1:0]   k_act;
    logic [PHASE_W-1:0] p_act;
    logic [1:0]         mode_act;

    logic [ACC_W-1:0]   acc_p0;
    logic               carry_p0;
    logic               vld_p0;

    logic [PHASE_W-1:0] ph_p1;
    logic               carry_p1;
    logic               vld_p1;

    // Extra top bit holds the accumulator carry-out.
    logic [ACC_W:0]     acc_sum;
    assign acc_sum = {1'b0, acc_p0} + {1'b0, k_act};

    // Active tuning registers: only a load strobe changes them, never acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_act    <= '0;
            p_act    <= '0;
            mode_act <= '0;
        end else if (load) begin
            k_act    <= k_in;
            p_act    <= p_in;
            mode_act <= mode;
        end
    end

    // ---- stage 1: phase accumulator, clear has priority over enable ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p0   <= '0;
            carry_p0 <= 1'b0;
            vld_p0   <= 1'b0;
        end else begin
            vld_p0 <= en & ~sync_clr;
            if (sync_clr) begin
                acc_p0   <= '0;
                carry_p0 <= 1'b0;
            end else if (en) begin
                acc_p0   <= acc_sum[ACC_W-1:0];
                carry_p0 <= acc_sum[ACC_W];
            end else begin
                carry_p0 <= 1'b0;
            end
        end
    end

    // ---- stage 2: truncate accumulator and add phase offset ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_p1    <= '0;
            carry_p1 <= 1'b0;
            vld_p1   <= 1'b0;
        end else begin
            ph_p1    <= acc_p0[ACC_W-1 -: PHASE_W] + p_act;
            carry_p1 <= carry_p0;
            vld_p1   <= vld_p0;
        end
    end

    // ---- stage 3: waveform shaping and registered outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_out      <= 1'b0;
            wave_out   <= '0;
            wave_valid <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            f_out      <= ph_p1[PHASE_W-1];
            wave_out   <= shape_wave(ph_p1, mode_act);
            wave_valid <= vld_p1;
            wrap       <= carry_p1;
        end
    end

endmodule
